// File: rtl/gate_chk_pkg.sv
// Shared types for the logic-gate response checker and related gate benches.
package gate_chk_pkg;

   typedef enum logic [1:0] {FN_OR, FN_AND, FN_XOR, FN_NOR} gate_fn_e;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} chk_state_e;

   localparam int COMBOS = 4;
   localparam logic [COMBOS-1:0] COV_FULL = '1;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden result of a 2-input gate for the selected function.
module gate_ref_model
   import gate_chk_pkg::*;
(
   input  gate_fn_e fn,
   input  logic     a,
   input  logic     b,
   output logic     exp_c
);

   always_comb begin
      exp_c = 1'b0;
      case (fn)
         FN_OR:   exp_c = a | b;
         FN_AND:  exp_c = a & b;
         FN_XOR:  exp_c = a ^ b;
         FN_NOR:  exp_c = ~(a | b);
         default: exp_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_checker.sv
// Response checker for a 2-input gate: counts pass/fail and truth-table coverage.
// Optional first-failure capture is built when GATE_CHK_FIRST_ERR_EN is defined.
module gate_checker
   import gate_chk_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int MIN_SAMP = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        func_sel,
   input  logic              in_valid,
   input  logic              in_a,
   input  logic              in_b,
   input  logic              in_c,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic [COMBOS-1:0] coverage,
   output logic              busy,
   output logic              done,
   output logic              err
`ifdef GATE_CHK_FIRST_ERR_EN
   ,
   output logic              first_err_vld,
   output logic [2:0]        first_err_vec
`endif
);

   localparam int SAMP_W = $clog2(MIN_SAMP + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [SAMP_W-1:0] SAMP_TGT = SAMP_W'(MIN_SAMP);

   chk_state_e        state, state_nxt;
   gate_fn_e          fn_q;
   logic [SAMP_W-1:0] samp_cnt, samp_nxt;
   logic [COMBOS-1:0] cov_nxt;
   logic              accept, exp_c, match, finish;

   gate_ref_model u_ref (
      .fn    (fn_q),
      .a     (in_a),
      .b     (in_b),
      .exp_c (exp_c)
   );

   // A sample in the same cycle as start belongs to the old run and is dropped.
   assign accept   = in_valid && (state == ST_RUN) && !start;
   assign match    = (in_c == exp_c);
   assign cov_nxt  = coverage | ({{(COMBOS-1){1'b0}}, 1'b1} << {in_a, in_b});
   assign samp_nxt = (samp_cnt == SAMP_TGT) ? samp_cnt : samp_cnt + 1'b1;
   assign finish   = accept && (cov_nxt == COV_FULL) && (samp_nxt >= SAMP_TGT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            if (start)       state_nxt = ST_RUN;
            else if (finish) state_nxt = ST_DONE;
         end
         ST_DONE: if (start) state_nxt = ST_RUN;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // An unknown in_c makes match false, so such a sample lands in fail_cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fn_q     <= FN_OR;
         pass_cnt <= '0;
         fail_cnt <= '0;
         coverage <= '0;
         samp_cnt <= '0;
      end else if (start) begin
         fn_q     <= gate_fn_e'(func_sel);
         pass_cnt <= '0;
         fail_cnt <= '0;
         coverage <= '0;
         samp_cnt <= '0;
      end else if (accept) begin
         if (match) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
         end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
         end
         coverage <= cov_nxt;
         samp_cnt <= samp_nxt;
      end
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);
   assign err  = (fail_cnt != '0);

`ifdef GATE_CHK_FIRST_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_err_vld <= 1'b0;
         first_err_vec <= 3'b000;
      end else if (start) begin
         first_err_vld <= 1'b0;
         first_err_vec <= 3'b000;
      end else if (accept && !match && !first_err_vld) begin
         first_err_vld <= 1'b1;
         first_err_vec <= {in_a, in_b, in_c};
      end
   end
`endif

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench for gate_checker: truth-table reference model, directed and random stimulus.
// Define GATE_CHK_FIRST_ERR_EN to also check the first-failure capture outputs.
module tb_gate_checker;

   localparam int CNT_W    = 3;
   localparam int MIN_SAMP = 6;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       func_sel = 2'b00;
   logic             in_valid = 1'b0;
   logic             in_a = 1'b0;
   logic             in_b = 1'b0;
   logic             in_c = 1'b0;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic [3:0]       coverage;
   logic             busy;
   logic             done;
   logic             err;
`ifdef GATE_CHK_FIRST_ERR_EN
   logic             first_err_vld;
   logic [2:0]       first_err_vec;
`endif

   gate_checker #(.CNT_W(CNT_W), .MIN_SAMP(MIN_SAMP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .func_sel (func_sel),
      .in_valid (in_valid),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_c     (in_c),
      .pass_cnt (pass_cnt),
      .fail_cnt (fail_cnt),
      .coverage (coverage),
      .busy     (busy),
      .done     (done),
      .err      (err)
`ifdef GATE_CHK_FIRST_ERR_EN
      ,
      .first_err_vld (first_err_vld),
      .first_err_vec (first_err_vec)
`endif
   );

   always #5 clk = ~clk;

   // Expected visible outputs after one clock edge.
   typedef struct {
      int pass;
      int fail;
      int cov;
      int busy;
      int done;
      int err;
      int fe_vld;
      int fe_vec;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: truth tables indexed by {a,b}, plain integer counts.
   bit [3:0] truth [4] = '{4'b1110, 4'b1000, 4'b0110, 4'b0001};
   bit       m_running;
   bit       m_finished;
   int       m_fn;
   int       m_pass;
   int       m_fail;
   int       m_samples;
   bit [3:0] m_cov;
   bit       m_fe_vld;
   int       m_fe_vec;

   task automatic modelClear();
      m_pass = 0; m_fail = 0; m_samples = 0; m_cov = 4'b0000;
      m_fe_vld = 1'b0; m_fe_vec = 0;
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.pass   = m_pass;
      e.fail   = m_fail;
      e.cov    = int'(m_cov);
      e.busy   = int'(m_running);
      e.done   = int'(m_finished);
      e.err    = (m_fail != 0) ? 1 : 0;
      e.fe_vld = int'(m_fe_vld);
      e.fe_vec = m_fe_vec;
      return e;
   endfunction

   task automatic checkOutput(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // One clock of stimulus; the model predicts the state after the next edge.
   task automatic applyStimulus(input bit s, input int fs, input bit v,
                                input bit a, input bit b, input bit c);
      int idx;
      @(negedge clk);
      start    = s;
      func_sel = fs[1:0];
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_c     = c;
      idx      = {30'd0, a, b};
      if (s) begin
         modelClear();
         m_fn       = fs & 3;
         m_running  = 1'b1;
         m_finished = 1'b0;
      end else if (v && m_running) begin
         if (c == truth[m_fn][idx]) begin
            if (m_pass < CNT_MAX) m_pass++;
         end else begin
            if (m_fail < CNT_MAX) m_fail++;
            if (!m_fe_vld) begin
               m_fe_vld = 1'b1;
               m_fe_vec = {29'd0, a, b, c};
            end
         end
         m_cov[idx] = 1'b1;
         m_samples++;
         if (m_cov == 4'b1111 && m_samples >= MIN_SAMP) begin
            m_running  = 1'b0;
            m_finished = 1'b1;
         end
      end
      exp_q.push_back(snapshot());
   endtask

   task automatic sampleVec(input bit [2:0] v);
      applyStimulus(1'b0, 0, 1'b1, v[2], v[1], v[0]);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic startRun(input int fs);
      applyStimulus(1'b1, fs, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".pass_cnt"}, int'(pass_cnt), 0);
      checkOutput({tag, ".fail_cnt"}, int'(fail_cnt), 0);
      checkOutput({tag, ".coverage"}, int'(coverage), 0);
      checkOutput({tag, ".busy"}, int'(busy), 0);
      checkOutput({tag, ".done"}, int'(done), 0);
      checkOutput({tag, ".err"}, int'(err), 0);
`ifdef GATE_CHK_FIRST_ERR_EN
      checkOutput({tag, ".first_err_vld"}, int'(first_err_vld), 0);
      checkOutput({tag, ".first_err_vec"}, int'(first_err_vec), 0);
`endif
   endtask

   // Reset asserted between edges must clear outputs without waiting for a clock.
   task automatic doAsyncReset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      modelClear();
      m_running  = 1'b0;
      m_finished = 1'b0;
      m_fn       = 0;
      start = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      if (in_valid)
         assert (!$isunknown({in_a, in_b, in_c}))
         else $error("[TB] unknown value on gate inputs while valid");
   end

   // Monitor: pop one prediction per edge and compare against the DUT.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("pass_cnt", int'(pass_cnt), e.pass);
            checkOutput("fail_cnt", int'(fail_cnt), e.fail);
            checkOutput("coverage", int'(coverage), e.cov);
            checkOutput("busy", int'(busy), e.busy);
            checkOutput("done", int'(done), e.done);
            checkOutput("err", int'(err), e.err);
`ifdef GATE_CHK_FIRST_ERR_EN
            checkOutput("first_err_vld", int'(first_err_vld), e.fe_vld);
            checkOutput("first_err_vec", int'(first_err_vec), e.fe_vec);
`endif
         end
      end
   end

   initial begin
      bit s, v, a, b, c;
      int fs, drain;
      modelClear();
      m_running = 1'b0; m_finished = 1'b0; m_fn = 0;

      #2;
      checkAllZero("power_on_reset");
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] OR, all combos, done after MIN_SAMP samples");
      startRun(0);
      sampleVec(3'b000); sampleVec(3'b011); sampleVec(3'b101); sampleVec(3'b111);
      sampleVec(3'b011); sampleVec(3'b000);
      idleCycle(); idleCycle();

      $display("[TB] OR with one wrong response");
      startRun(0);
      sampleVec(3'b000); sampleVec(3'b011); sampleVec(3'b100); sampleVec(3'b111);
      sampleVec(3'b101); sampleVec(3'b011);
      idleCycle();

      $display("[TB] AND, coverage full but too few samples");
      startRun(1);
      sampleVec(3'b000); sampleVec(3'b010); sampleVec(3'b100); sampleVec(3'b111);
      sampleVec(3'b111); idleCycle(); idleCycle();
      sampleVec(3'b000); idleCycle();

      $display("[TB] XOR fail counter saturation");
      startRun(2);
      for (int i = 0; i < 9; i++) sampleVec(3'b010);
      idleCycle();

      $display("[TB] async reset mid-run");
      startRun(0);
      sampleVec(3'b011); sampleVec(3'b101);
      doAsyncReset();

      $display("[TB] start and in_valid in the same cycle");
      startRun(0);
      sampleVec(3'b011);
      applyStimulus(1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b1);
      idleCycle();

      $display("[TB] samples ignored in DONE, restart as NOR");
      sampleVec(3'b000); sampleVec(3'b011); sampleVec(3'b101); sampleVec(3'b110);
      sampleVec(3'b011); sampleVec(3'b000);
      sampleVec(3'b000); sampleVec(3'b111);
      startRun(3);
      sampleVec(3'b001); idleCycle();

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         s  = ($urandom_range(0, 29) == 0);
         fs = $urandom_range(0, 3);
         v  = ($urandom_range(0, 3) != 0);
         a  = $urandom_range(0, 1);
         b  = $urandom_range(0, 1);
         c  = truth[m_fn][{a, b}];
         if ($urandom_range(0, 4) == 0) c = ~c;
         applyStimulus(s, fs, v, a, b, c);
         if ($urandom_range(0, 199) == 0) doAsyncReset();
      end
      idleCycle();

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      #2;
      checkOutput("scoreboard_drain", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
